instr_fetch: RTL and testbench

//  Instruction fetch stage: holds the PC, fetches one instruction per transaction from a variable-latency

---
 rtl/mips_pkg.sv | 20 ++
 rtl/next_pc_calc.sv | 41 ++++
 rtl/instr_fetch.sv | 147 ++++++++++++++
 tb/tb_instr_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the instruction fetch stage and its helpers.
//   - fetch_state_t    : fetch FSM states (FETCH, WAIT_ACCEPT)
//   - OPCODE_W         : width of the primary opcode field instr[31:26]
//   - JUMP_TGT_W       : width of the J-type target field instr[25:0]
//   - RESET_PC_DEFAULT : default PC loaded by reset (word aligned)
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int          OPCODE_W         = 6;
  localparam int          JUMP_TGT_W       = 26;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH       = 1'b0,
    WAIT_ACCEPT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc
//   Combinational next-PC selection for the fetch stage.
//   Priority: jump > taken branch (branch & zero) > sequential (pc + 4).
//   All arithmetic is modulo 2^DATA_WIDTH.
// Ports
//   pc_plus4  in  DATA_WIDTH  pc + 4 of the retiring instruction
//   jump_tgt  in  JUMP_TGT_W  instr[25:0] of the retiring instruction
//   imm       in  DATA_WIDTH  sign-extended branch immediate (word offset)
//   branch    in  1           decoded beq
//   jump      in  1           decoded j
//   zero      in  1           ALU zero flag
//   next_pc   out DATA_WIDTH  address of the next instruction to fetch
// ---------------------------------------------------------------------------
module next_pc_calc
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc_plus4,
  input  logic [JUMP_TGT_W-1:0] jump_tgt,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  branch,
  input  logic                  jump,
  input  logic                  zero,
  output logic [DATA_WIDTH-1:0] next_pc
);

  always_comb begin
    // NOTE: assigning a default before any conditional keeps this block
    // purely combinational; a missing default on any path infers a latch.
    next_pc = pc_plus4;
    if (jump) begin
      // Jump stays inside the 256 MB region of the delay-slot address.
      next_pc = {pc_plus4[DATA_WIDTH-1 -: 4], jump_tgt, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + (imm << 2);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage. Holds the PC, issues one read per instruction to
//   a variable-latency instruction memory, presents the returned word to the
//   control decoder and, when downstream accepts it, advances the PC using
//   the decoder's branch/jump decision and the ALU zero flag. Only one
//   instruction is in flight at any time.
//
// Optional feature (macro FETCH_PERF_EN):
//   adds fetch_count_out (accepted instructions) and wait_count_out (FETCH
//   cycles spent waiting for memory). Both clear on reset and wrap.
//
// Ports
//   clock_in         in   1   rising-edge clock
//   reset_in         in   1   synchronous active-high reset
//   imem_req_out     out  1   memory read request (forced low while reset_in)
//   imem_addr_out    out  32  request byte address (= pc)
//   imem_ready_in    in   1   memory data valid this cycle
//   imem_data_in     in   32  instruction word from memory
//   instr_out        out  32  latched instruction
//   opcode_out       out  6   instr_out[31:26]
//   pc_plus4_out     out  32  pc + 4 of the presented instruction
//   instr_valid_out  out  1   presented instruction is valid
//   instr_accept_in  in   1   downstream retires the presented instruction
//   branch_in        in   1   decoded beq (used on accept)
//   jump_in          in   1   decoded j (used on accept)
//   zero_in          in   1   ALU zero flag (used on accept)
//   branch_imm_in    in   32  sign-extended branch immediate
//   fetch_count_out  out  32  (FETCH_PERF_EN) accepted instruction count
//   wait_count_out   out  32  (FETCH_PERF_EN) memory wait cycle count
// ---------------------------------------------------------------------------
module instr_fetch
  import mips_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  output logic                  imem_req_out,
  output logic [DATA_WIDTH-1:0] imem_addr_out,
  input  logic                  imem_ready_in,
  input  logic [DATA_WIDTH-1:0] imem_data_in,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [OPCODE_W-1:0]   opcode_out,
  output logic [DATA_WIDTH-1:0] pc_plus4_out,
  output logic                  instr_valid_out,
  input  logic                  instr_accept_in,
  input  logic                  branch_in,
  input  logic                  jump_in,
  input  logic                  zero_in,
`ifdef FETCH_PERF_EN
  input  logic [DATA_WIDTH-1:0] branch_imm_in,
  output logic [31:0]           fetch_count_out,
  output logic [31:0]           wait_count_out
`else
  input  logic [DATA_WIDTH-1:0] branch_imm_in
`endif
);

  fetch_state_t          state, state_next;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  fetch_done;  // memory returned the word this cycle
  logic                  retire;      // presented instruction accepted

  // ---- FSM state register --------------------------------------------------
  always_ff @(posedge clock_in) begin
    // NOTE: clocked state always uses non-blocking (<=) so every register
    // samples pre-edge values; blocking here would create ordering races.
    if (reset_in) state <= FETCH;
    else          state <= state_next;
  end

  // ---- FSM next-state and strobes -----------------------------------------
  always_comb begin
    state_next   = state;
    imem_req_out = 1'b0;
    fetch_done   = 1'b0;
    retire       = 1'b0;
    case (state)
      FETCH: begin
        // The request is masked during reset so a pending transaction is
        // abandoned in the same cycle reset is seen.
        imem_req_out = ~reset_in;
        if (imem_ready_in) begin
          fetch_done = 1'b1;
          state_next = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT: begin
        if (instr_accept_in) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // ---- PC register and instruction latch -----------------------------------
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      pc           <= RESET_PC;
      instr_out    <= '0;
      pc_plus4_out <= '0;
    end else begin
      if (fetch_done) begin
        instr_out    <= imem_data_in;
        pc_plus4_out <= pc + DATA_WIDTH'(4);
      end
      if (retire) begin
        pc <= next_pc;
      end
    end
  end

  next_pc_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_next_pc_calc (
    .pc_plus4 (pc_plus4_out),
    .jump_tgt (instr_out[JUMP_TGT_W-1:0]),
    .imm      (branch_imm_in),
    .branch   (branch_in),
    .jump     (jump_in),
    .zero     (zero_in),
    .next_pc  (next_pc)
  );

  assign imem_addr_out   = pc;
  assign instr_valid_out = (state == WAIT_ACCEPT);
  assign opcode_out      = instr_out[DATA_WIDTH-1 -: OPCODE_W];

`ifdef FETCH_PERF_EN
  // ---- Performance counters ------------------------------------------------
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      fetch_count_out <= '0;
      wait_count_out  <= '0;
    end else begin
      if (retire) fetch_count_out <= fetch_count_out + 32'd1;
      if ((state == FETCH) && !imem_ready_in) wait_count_out <= wait_count_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch. A transaction-level model tracks the
//   architectural PC, the presented instruction and whether a fetch is
//   outstanding; a compare process checks every DUT output against it on the
//   falling edge. Directed sequences reach the interesting PCs (branch back,
//   jump with branch, wrap at 2^32, reset during fetch) and pin them with
//   literal addresses; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clock_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ready_in = 1'b0;
  logic [31:0] imem_data_in = '0;
  logic [31:0] instr_out;
  logic [5:0]  opcode_out;
  logic [31:0] pc_plus4_out;
  logic        instr_valid_out;
  logic        instr_accept_in = 1'b0;
  logic        branch_in = 1'b0;
  logic        jump_in = 1'b0;
  logic        zero_in = 1'b0;
  logic [31:0] branch_imm_in = '0;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_out;
  logic [31:0] wait_count_out;
`endif

  always #5 clock_in = ~clock_in;

  instr_fetch dut (
    .clock_in        (clock_in),
    .reset_in        (reset_in),
    .imem_req_out    (imem_req_out),
    .imem_addr_out   (imem_addr_out),
    .imem_ready_in   (imem_ready_in),
    .imem_data_in    (imem_data_in),
    .instr_out       (instr_out),
    .opcode_out      (opcode_out),
    .pc_plus4_out    (pc_plus4_out),
    .instr_valid_out (instr_valid_out),
    .instr_accept_in (instr_accept_in),
    .branch_in       (branch_in),
    .jump_in         (jump_in),
    .zero_in         (zero_in),
`ifdef FETCH_PERF_EN
    .branch_imm_in   (branch_imm_in),
    .fetch_count_out (fetch_count_out),
    .wait_count_out  (wait_count_out)
`else
    .branch_imm_in   (branch_imm_in)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- Behavioural model ---------------------------------------------------
  bit          m_fetching = 1'b1;  // a memory request is outstanding
  logic [31:0] m_pc       = '0;
  logic [31:0] m_instr    = '0;
  logic [31:0] m_pc4      = '0;
  logic [31:0] m_fcnt     = '0;
  logic [31:0] m_wcnt     = '0;

  // Expected outputs for the current cycle.
  bit          cmp_en = 1'b0;
  bit          e_req, e_valid;
  logic [31:0] e_addr, e_instr, e_pc4, e_fcnt, e_wcnt;

  always @(negedge clock_in) begin
    if (cmp_en) begin
      check("imem_req", 32'(imem_req_out), 32'(e_req));
      if (e_req) check("imem_addr", imem_addr_out, e_addr);
      check("instr_valid", 32'(instr_valid_out), 32'(e_valid));
      check("instr", instr_out, e_instr);
      check("opcode", 32'(opcode_out), e_instr >> 26);
      check("pc_plus4", pc_plus4_out, e_pc4);
`ifdef FETCH_PERF_EN
      check("fetch_count", fetch_count_out, e_fcnt);
      check("wait_count", wait_count_out, e_wcnt);
`endif
    end
  end

  // One clock cycle: drive inputs, publish expectations, then advance the
  // model by what the rising edge must do with those inputs.
  task automatic cycle(input bit rst, input bit rdy, input logic [31:0] data,
                       input bit acc, input bit br, input bit jmp, input bit z,
                       input logic [31:0] imm);
    reset_in        = rst;
    imem_ready_in   = rdy;
    imem_data_in    = data;
    instr_accept_in = acc;
    branch_in       = br;
    jump_in         = jmp;
    zero_in         = z;
    branch_imm_in   = imm;
    e_req   = m_fetching && !rst;
    e_addr  = m_pc;
    e_valid = !m_fetching;
    e_instr = m_instr;
    e_pc4   = m_pc4;
    e_fcnt  = m_fcnt;
    e_wcnt  = m_wcnt;
    @(posedge clock_in);
    if (rst) begin
      m_fetching = 1'b1;
      m_pc = 32'h0; m_instr = '0; m_pc4 = '0; m_fcnt = '0; m_wcnt = '0;
    end else if (m_fetching) begin
      if (!rdy) m_wcnt = m_wcnt + 1;
      else begin
        m_instr    = data;
        m_pc4      = m_pc + 4;
        m_fetching = 1'b0;
      end
    end else if (acc) begin
      m_fcnt     = m_fcnt + 1;
      m_fetching = 1'b1;
      if (jmp)           m_pc = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
      else if (br && z)  m_pc = m_pc4 + imm * 4;
      else               m_pc = m_pc4;
    end
    cmp_en = 1'b1;
    #1;
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // Fetch with `lat` not-ready cycles; accept/branch noise must be ignored.
  task automatic fetch(input int lat, input logic [31:0] data);
    for (int i = 0; i < lat; i++) cycle(0, 0, $urandom, rb(), rb(), rb(), rb(), $urandom);
    cycle(0, 1, data, rb(), rb(), rb(), rb(), $urandom);
  endtask

  // Hold for `dly` cycles (ready noise must be ignored), then accept.
  task automatic retire(input int dly, input bit br, input bit jmp, input bit z,
                        input logic [31:0] imm);
    for (int i = 0; i < dly; i++) cycle(0, rb(), $urandom, 0, rb(), rb(), rb(), $urandom);
    cycle(0, rb(), $urandom, 1, br, jmp, z, imm);
  endtask

  initial begin
    // 1. Reset, zero-latency memory.
    cycle(1, 1, $urandom, 0, 0, 0, 0, 0);
    cycle(1, 1, $urandom, 0, 0, 0, 0, 0);
    check("reset_addr", imem_addr_out, 32'h0);
    check("reset_valid", 32'(instr_valid_out), 32'h0);
    check("reset_instr", instr_out, 32'h0);
    check("reset_pc4", pc_plus4_out, 32'h0);
    fetch(0, 32'hAC22_0008);
    check("t1_valid", 32'(instr_valid_out), 32'h1);
    check("t1_opcode", 32'(opcode_out), 32'h2B);
    check("t1_pc4", pc_plus4_out, 32'h4);
    retire(0, 0, 0, 0, 0);

    // 2. Ready three cycles late: address stable for four request cycles.
    for (int i = 0; i < 3; i++) begin
      check("t2_addr_stable", imem_addr_out, 32'h4);
      cycle(0, 0, $urandom, 0, 0, 0, 0, 0);
      check("t2_not_valid", 32'(instr_valid_out), 32'h0);
    end
    check("t2_addr_stable", imem_addr_out, 32'h4);
    cycle(0, 1, 32'h8C01_0004, 0, 0, 0, 0, 0);
    check("t2_valid", 32'(instr_valid_out), 32'h1);
    check("t2_opcode", 32'(opcode_out), 32'h23);

    // 3. Taken backward branch from 0x10, then not-taken from 0x10.
    retire(1, 1, 0, 1, 32'h0000_0002);          // 0x8 + 8
    check("t3_pc_0x10", imem_addr_out, 32'h10);
    fetch(1, $urandom & 32'h73FF_FFFF);
    retire(1, 1, 0, 1, 32'hFFFF_FFFE);
    check("t3_branch_back", imem_addr_out, 32'h0C);
    fetch(0, $urandom & 32'h73FF_FFFF);
    retire(0, 0, 0, 0, 0);
    check("t3_pc_0x10b", imem_addr_out, 32'h10);
    fetch(2, $urandom & 32'h73FF_FFFF);
    retire(0, 1, 0, 0, 32'hFFFF_FFFE);
    check("t3_not_taken", imem_addr_out, 32'h14);

    // 5. Wrap: reach 0xFFFF_FFFC then fall through to 0.
    fetch(0, $urandom);
    retire(0, 1, 0, 1, 32'hFFFF_FFF9);          // 0x18 - 28
    check("t5_pc_top", imem_addr_out, 32'hFFFF_FFFC);
    fetch(1, $urandom);
    check("t5_pc4_wrap", pc_plus4_out, 32'h0);
    retire(1, 0, 0, 0, 0);
    check("t5_wrap", imem_addr_out, 32'h0);

    // 4. Jump wins over branch at 0x4000_0000.
    fetch(0, $urandom);
    retire(0, 1, 0, 1, 32'h0FFF_FFFF);          // 0x4 + 0x3FFF_FFFC
    check("t4_pc", imem_addr_out, 32'h4000_0000);
    fetch(0, 32'h0800_0010);
    retire(0, 1, 1, 1, 32'h0000_0100);
    check("t4_jump", imem_addr_out, 32'h4000_0040);

    // 6. Reset during FETCH with same-cycle ready.
    cycle(0, 0, $urandom, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    check("t6_no_valid", 32'(instr_valid_out), 32'h0);
    check("t6_addr", imem_addr_out, 32'h0);
`ifdef FETCH_PERF_EN
    check("t6_fcnt", fetch_count_out, 32'h0);
    check("t6_wcnt", wait_count_out, 32'h0);
`endif

    // Randomized phase.
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 24) == 0) begin
        cycle(1, rb(), $urandom, rb(), rb(), rb(), rb(), $urandom);
      end else begin
        fetch(int'($urandom_range(0, 3)), $urandom);
        if ($urandom_range(0, 19) == 0)
          cycle(1, rb(), $urandom, rb(), rb(), rb(), rb(), $urandom);
        else
          retire(int'($urandom_range(0, 3)), rb(), ($urandom_range(0, 3) == 0), rb(),
                 ($urandom_range(0, 1) == 0) ? 32'($signed($urandom_range(0, 64)) - 32) : $urandom);
      end
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
